vect_mem_ctrl: RTL and testbench
================================

Name: vect_mem_ctrl

Overview:
Vector memory access controller between the pipeline MEM stage and vectmanager (256-bit row, 16 lanes × 16-bit elements).
- Accepts one load/store per request handshake with an element-granular address.
- Performs aligned accesses directly.
- Splits unaligned accesses into two-row reads, merges lanes, and read-modify-writes both rows for stores.
- Returns load data or a store acknowledge through a single-cycle response pulse.

Parameters:
ADDR_W, 32, element address width (16-bit element units)
ELEM_W, 16, lane width in bits
LANES, 16, lanes per vector row (power of 2)
DATA_W, 256, ELEM_W*LANES

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  element address of lane 0
req_wdata  in  DATA_W  store data; lane i = bits [16i+15:16i]
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  load result (zero for stores)
mem_we  out  1  to vectmanager we
mem_a  out  ADDR_W  to vectmanager a; low log2(LANES) bits always 0
mem_wd  out  DATA_W  to vectmanager wd
mem_rd  in  DATA_W  from vectmanager rd; combinational read of mem_a

Behaviour:
- Clock is clk; reset is synchronous, active-low on rst.
- Address split:
  - R = req_addr[ADDR_W-1:4]; row address A0 = {R, 4'b0}.
  - k = req_addr[3:0]; A1 = {R+1, 4'b0}, wrapping mod 2^(ADDR_W-4).
- Accept: req_valid & req_ready at edge E0 latches we, addr, wdata. req_valid is ignored outside IDLE.
- States: IDLE, RD0, RD1, WR0, WR1, RESP.
- Load, k=0: IDLE→RD0→RESP. RD0 drives mem_a=A0 and captures mem_rd into row0 buffer.
- Load, k≠0: IDLE→RD0→RD1→RESP. RD1 drives mem_a=A1 and captures row1.
  - Result lane i = row0 lane k+i for i<16-k.
  - Result lane i = row1 lane i-(16-k) for i≥16-k.
- Store, k=0: IDLE→WR0→RESP. WR0 drives mem_we=1, mem_a=A0, mem_wd=req_wdata.
- Store, k≠0: IDLE→RD0→RD1→WR0→WR1→RESP.
  - WR0 writes row0 with lanes k..15 replaced by wdata lanes 0..15-k.
  - WR1 writes row1 with lanes 0..k-1 replaced by wdata lanes 16-k..15.
  - All other lanes are written back unchanged.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - resp_rdata = merged load data, or 0 for stores.
  - Next state is IDLE. resp_rdata holds its value until the next response.
- Latency (resp_valid asserted in the cycle after edge E0+n):
  - aligned load n=2; unaligned load n=3
  - aligned store n=2; unaligned store n=5
  - Back-to-back requests: next accept earliest on the edge that ends RESP+IDLE, i.e. one IDLE cycle between operations.
- mem_we is combinational:
  - 1 only in WR0/WR1 and while rst=1.
  - 0 during any cycle with rst=0.
- mem_a = 0 and mem_wd = 0 in IDLE and RESP.
- Reset values: state IDLE; req_ready=0 during reset, 1 in the first cycle after; resp_valid=0; resp_rdata=0; mem_we=0; mem_a=0; mem_wd=0; internal buffers 0.
- Reset mid-operation:
  - Aborts at the next edge with no response.
  - A WR0 already committed stays in memory; WR1 is not performed.
- Top-of-memory wrap: R=all-ones with k≠0 reads/writes row 0 as row1.
- No response backpressure: consumer must sample resp_valid.

Test Plan:
- Preload rows at a=32 with lanes 0x0020..0x002F and at a=48 with 0x0030..0x003F. Aligned load addr 32 → resp_valid 2 cycles after accept; rdata lanes 0x0020..0x002F; mem_we never 1.
- Unaligned load addr 37 → mem_a=32 then 48; resp after 3; rdata lanes 0..15 = 0x0025..0x0034.
- Aligned store addr 48, wdata lanes 0xF55F repeated → one mem_we pulse at a=48; reload of 48 returns all 0xF55F; row 32 unchanged.
- Unaligned store addr 45, wdata lanes 0xA000+i:
  - row 32 lanes 13..15 = 0xA000..0xA002, lanes 0..12 unchanged.
  - row 48 lanes 0..12 = 0xA003..0xA00F, lanes 13..15 unchanged.
  - resp after 5.
- Drive rst=0 during WR1 of an unaligned store to addr 45 → row 32 modified, row 48 untouched, no resp_valid; req_ready=1 one cycle after rst returns high.
- Wrap case: addr 0xFFFFFFF9 load → mem_a=0xFFFFFFF0 then 0x00000000. Then hold req_valid high continuously → accepts spaced with one IDLE cycle between operations.

Source files
------------

// File: rtl/vect_mem_ctrl.sv
// ---------------------------------------------------------------------------
// vect_mem_ctrl
//
// Vector memory access controller between the pipeline MEM stage and the
// vectmanager row memory. One memory row holds LANES elements of ELEM_W bits
// (256 bits by default). Requests carry an element-granular address. Aligned
// accesses touch a single row. Unaligned accesses span two rows:
//   - loads read both rows and merge the lanes into one vector;
//   - stores read both rows, splice in the new lanes and write both rows back.
// Each operation completes with a one-cycle response pulse.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active low
//   req_valid   request present
//   req_ready   controller idle and able to accept a request
//   req_we      1 = store, 0 = load
//   req_addr    element address of lane 0 of the vector
//   req_wdata   store data, lane i in bits [ELEM_W*i +: ELEM_W]
//   resp_valid  one-cycle completion pulse
//   resp_rdata  load result (zero for stores), held until the next response
//   mem_we      row write enable to vectmanager
//   mem_a       row address to vectmanager (low lane-index bits always 0)
//   mem_wd      row write data to vectmanager
//   mem_rd      row read data from vectmanager (combinational read of mem_a)
// ---------------------------------------------------------------------------
module vect_mem_ctrl #(
   parameter int ADDR_W = 32,
   parameter int ELEM_W = 16,
   parameter int LANES  = 16,
   parameter int DATA_W = ELEM_W * LANES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
);

   localparam int LW = $clog2(LANES);
   localparam int RW = ADDR_W - LW;

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      WR0,
      WR1,
      RESP
   } stateT;

   stateT             state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] row0_q, row0_d;
   logic [DATA_W-1:0] row1_q, row1_d;
   logic              respValid_q, respValid_d;
   logic [DATA_W-1:0] respRdata_q, respRdata_d;

   logic [RW-1:0]     rowIdx;
   logic [RW-1:0]     rowIdxNext;
   logic [LW-1:0]     laneOff;
   logic              isAligned;
   logic [ADDR_W-1:0] rowAddr0;
   logic [ADDR_W-1:0] rowAddr1;
   int                laneOffInt;

   logic [DATA_W-1:0] loadMerged;
   logic [DATA_W-1:0] wrRow0;
   logic [DATA_W-1:0] wrRow1;

   // The latched address splits into a row index and a lane offset. The
   // second row of an unaligned access is simply the next row index, which
   // wraps naturally from the top of memory back to row 0.
   assign rowIdx     = addr_q[ADDR_W-1:LW];
   assign laneOff    = addr_q[LW-1:0];
   assign rowIdxNext = rowIdx + RW'(1);
   assign isAligned  = (laneOff == '0);
   assign rowAddr0   = {rowIdx, {LW{1'b0}}};
   assign rowAddr1   = {rowIdxNext, {LW{1'b0}}};
   assign laneOffInt = int'(laneOff);

   // Lane shuffling shared by loads and stores. For a load, result lane i
   // comes from row0 lane k+i while that exists, and from the start of row1
   // after that. For a store, the request vector is split the same way:
   // its first LANES-k lanes land at the top of row0 and the remaining k
   // lanes land at the bottom of row1; every other lane keeps the value read
   // from memory. With k=0 this degenerates to plain row0 / plain wdata, so
   // the aligned paths reuse the same logic.
   always_comb begin
      loadMerged = '0;
      wrRow0     = '0;
      wrRow1     = '0;
      for (int i = 0; i < LANES; i++) begin
         if (i < LANES - laneOffInt) begin
            loadMerged[i*ELEM_W +: ELEM_W] = row0_q[(laneOffInt + i)*ELEM_W +: ELEM_W];
         end else begin
            loadMerged[i*ELEM_W +: ELEM_W] = row1_q[(i + laneOffInt - LANES)*ELEM_W +: ELEM_W];
         end

         if (i >= laneOffInt) begin
            wrRow0[i*ELEM_W +: ELEM_W] = wdata_q[(i - laneOffInt)*ELEM_W +: ELEM_W];
         end else begin
            wrRow0[i*ELEM_W +: ELEM_W] = row0_q[i*ELEM_W +: ELEM_W];
         end

         if (i < laneOffInt) begin
            wrRow1[i*ELEM_W +: ELEM_W] = wdata_q[(i + LANES - laneOffInt)*ELEM_W +: ELEM_W];
         end else begin
            wrRow1[i*ELEM_W +: ELEM_W] = row1_q[i*ELEM_W +: ELEM_W];
         end
      end
   end

   // Next-state and output logic. Every access path walks a subset of
   // RD0 -> RD1 -> WR0 -> WR1 -> RESP:
   //   aligned load    : RD0, RESP
   //   unaligned load  : RD0, RD1, RESP
   //   aligned store   : WR0, RESP
   //   unaligned store : RD0, RD1, WR0, WR1, RESP
   // The memory-side outputs are forced to zero whenever reset is asserted so
   // that an operation aborted mid-flight never issues another write, even in
   // the cycle before the reset edge takes effect.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      row0_d      = row0_q;
      row1_d      = row1_q;
      respValid_d = 1'b0;
      respRdata_d = respRdata_q;
      req_ready   = 1'b0;
      mem_we      = 1'b0;
      mem_a       = '0;
      mem_wd      = '0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (req_we && (req_addr[LW-1:0] == '0)) begin
                  state_d = WR0;
               end else begin
                  state_d = RD0;
               end
            end
         end

         RD0: begin
            mem_a  = rowAddr0;
            row0_d = mem_rd;
            state_d = isAligned ? RESP : RD1;
         end

         RD1: begin
            mem_a  = rowAddr1;
            row1_d = mem_rd;
            state_d = we_q ? WR0 : RESP;
         end

         WR0: begin
            mem_we  = 1'b1;
            mem_a   = rowAddr0;
            mem_wd  = wrRow0;
            state_d = isAligned ? RESP : WR1;
         end

         WR1: begin
            mem_we  = 1'b1;
            mem_a   = rowAddr1;
            mem_wd  = wrRow1;
            state_d = RESP;
         end

         RESP: begin
            respValid_d = 1'b1;
            respRdata_d = we_q ? '0 : loadMerged;
            state_d     = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (!rst) begin
         req_ready = 1'b0;
         mem_we    = 1'b0;
         mem_a     = '0;
         mem_wd    = '0;
      end
   end

   // State register and datapath registers. The response is registered, so
   // the completion pulse appears in the cycle after the RESP state and the
   // returned data stays stable until the next response overwrites it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         row0_q      <= '0;
         row1_q      <= '0;
         respValid_q <= 1'b0;
         respRdata_q <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         row0_q      <= row0_d;
         row1_q      <= row1_d;
         respValid_q <= respValid_d;
         respRdata_q <= respRdata_d;
      end
   end

   assign resp_valid = respValid_q;
   assign resp_rdata = respRdata_q;

endmodule

// File: tb/tb_vect_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vect_mem_ctrl
//
// Scoreboard bench for vect_mem_ctrl. Requests push their expected response
// (data and completion cycle) into a queue; an independent monitor pops and
// compares on every resp_valid pulse. A small row memory stands in for
// vectmanager so stores can be checked by inspecting the rows afterwards.
// ---------------------------------------------------------------------------
module tb_vect_mem_ctrl;

   localparam int AW = 32;
   localparam int EW = 16;
   localparam int NL = 16;
   localparam int DW = EW * NL;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          resp_valid;
   logic [DW-1:0] resp_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   vect_mem_ctrl #(
      .ADDR_W(AW),
      .ELEM_W(EW),
      .LANES (NL),
      .DATA_W(DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .mem_we    (mem_we),
      .mem_a     (mem_a),
      .mem_wd    (mem_wd),
      .mem_rd    (mem_rd)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Row memory standing in for vectmanager: 16 rows selected by mem_a[7:4],
   // so address 0xFFFFFFF0 lands in row 15 and address 0 in row 0.
   logic [DW-1:0] memRows [16];
   logic          preloadEn;
   logic [3:0]    preloadIdx;
   logic [DW-1:0] preloadData;

   assign mem_rd = memRows[mem_a[7:4]];

   always @(posedge clk) begin
      if (preloadEn) begin
         memRows[preloadIdx] <= preloadData;
      end else if (mem_we) begin
         memRows[mem_a[7:4]] <= mem_wd;
      end
   end

   // Cycle counter used to check response latency, and a count of write
   // pulses seen on the memory port.
   int cycleCount = 0;
   int weCount    = 0;

   always @(posedge clk) begin
      cycleCount <= cycleCount + 1;
   end

   always @(negedge clk) begin
      if (mem_we) begin
         weCount <= weCount + 1;
      end
   end

   typedef struct {
      logic [DW-1:0] data;
      int            due;
      string         name;
   } expT;

   expT expQ[$];
   expT monE;

   int checksMade   = 0;
   int checksFailed = 0;

   task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
      checksMade++;
      if (actual !== expected) begin
         checksFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic checkCount(input string name, input longint actual, input longint expected);
      checksMade++;
      if (actual != expected) begin
         checksFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: every response pulse must match the oldest outstanding
   // expectation, both in data and in the cycle it arrives.
   always @(negedge clk) begin
      if (rst && resp_valid) begin
         if (expQ.size() == 0) begin
            checksMade++;
            checksFailed++;
            $display("[TB] FAIL unexpected_resp: got resp_valid=1, expected no response");
         end else begin
            monE = expQ.pop_front();
            checkOutput({monE.name, "_rdata"}, resp_rdata, monE.data);
            checkCount({monE.name, "_latency"}, cycleCount, monE.due);
         end
      end
   end

   function automatic logic [DW-1:0] rampRow(input logic [15:0] base);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < NL; i++) begin
         r[i*EW +: EW] = base + 16'(i);
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] fillRow(input logic [15:0] v);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < NL; i++) begin
         r[i*EW +: EW] = v;
      end
      return r;
   endfunction

   // Issue one request, called at a falling edge. Waits (bounded) for
   // req_ready, then records the accept cycle and pushes the expected
   // response unless lat < 0 (aborted operation). Returns at the falling
   // edge following the accept, i.e. in the first cycle of the operation.
   task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [DW-1:0] expData,
                                input int lat, input string name, input bit hold,
                                output int acceptCycle);
      int waited;
      waited      = 0;
      acceptCycle = -1;
      req_we      = we;
      req_addr    = addr;
      req_wdata   = wdata;
      req_valid   = 1'b1;
      while (!req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         checksMade++;
         checksFailed++;
         $display("[TB] FAIL %s_accept: got req_ready=0 for 50 cycles, expected 1", name);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      acceptCycle = cycleCount;
      if (lat >= 0) begin
         expQ.push_back('{expData, acceptCycle + lat, name});
      end
      @(negedge clk);
      if (!hold) begin
         req_valid = 1'b0;
      end
   endtask

   // Wait (bounded) until all expected responses have been seen.
   task automatic waitDrain(input string name);
      int waited;
      waited = 0;
      while (expQ.size() != 0 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      checkCount({name, "_drain_pending"}, expQ.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   logic [DW-1:0] row2Exp;
   logic [DW-1:0] row3Exp;
   logic [DW-1:0] wrapExp;
   int            acc;
   int            prevAcc;
   int            weBefore;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got simulation time limit, expected test completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst         = 1'b0;
      req_valid   = 1'b0;
      req_we      = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      preloadEn   = 1'b0;
      preloadIdx  = '0;
      preloadData = '0;

      // Preload every row while the controller is held in reset.
      for (int r = 0; r < 16; r++) begin
         @(negedge clk);
         preloadEn  = 1'b1;
         preloadIdx = 4'(r);
         case (r)
            0:       preloadData = rampRow(16'h0A00);
            2:       preloadData = rampRow(16'h0020);
            3:       preloadData = rampRow(16'h0030);
            15:      preloadData = rampRow(16'h0F00);
            default: preloadData = '0;
         endcase
      end
      @(negedge clk);
      preloadEn = 1'b0;

      // Outputs while reset is held.
      checkCount("reset_req_ready", req_ready, 0);
      checkCount("reset_mem_we", mem_we, 0);
      checkCount("reset_mem_a", mem_a, 0);
      checkOutput("reset_mem_wd", mem_wd, '0);
      checkCount("reset_resp_valid", resp_valid, 0);
      checkOutput("reset_resp_rdata", resp_rdata, '0);

      rst = 1'b1;
      #1;
      checkCount("post_reset_req_ready", req_ready, 1);
      @(negedge clk);

      // Aligned load from row 32.
      weBefore = weCount;
      applyStimulus(1'b0, 32'd32, '0, rampRow(16'h0020), 2, "load32", 1'b0, acc);
      checkCount("load32_mem_a", mem_a, 32);
      waitDrain("load32");

      // Unaligned load from 37: rows 32 then 48.
      applyStimulus(1'b0, 32'd37, '0, rampRow(16'h0025), 3, "load37", 1'b0, acc);
      checkCount("load37_mem_a_row0", mem_a, 32);
      @(negedge clk);
      checkCount("load37_mem_a_row1", mem_a, 48);
      waitDrain("load37");
      checkCount("loads_no_write", weCount - weBefore, 0);

      // Aligned store to 48, then read it back.
      weBefore = weCount;
      applyStimulus(1'b1, 32'd48, fillRow(16'hF55F), '0, 2, "store48", 1'b0, acc);
      checkCount("store48_mem_a", mem_a, 48);
      waitDrain("store48");
      checkCount("store48_write_pulses", weCount - weBefore, 1);
      checkOutput("store48_row48", memRows[3], fillRow(16'hF55F));
      checkOutput("store48_row32_kept", memRows[2], rampRow(16'h0020));
      applyStimulus(1'b0, 32'd48, '0, fillRow(16'hF55F), 2, "reload48", 1'b0, acc);
      waitDrain("reload48");

      // Unaligned store to 45 (k=13) with lanes 0xA000+i.
      for (int i = 0; i < NL; i++) begin
         row2Exp[i*EW +: EW] = (i < 13) ? 16'(16'h0020 + i) : 16'(16'hA000 + i - 13);
         row3Exp[i*EW +: EW] = (i < 13) ? 16'(16'hA003 + i) : 16'hF55F;
      end
      weBefore = weCount;
      applyStimulus(1'b1, 32'd45, rampRow(16'hA000), '0, 5, "store45", 1'b0, acc);
      waitDrain("store45");
      checkCount("store45_write_pulses", weCount - weBefore, 2);
      checkOutput("store45_row32", memRows[2], row2Exp);
      checkOutput("store45_row48", memRows[3], row3Exp);

      // Unaligned store to 45 aborted by reset during WR1: only row 32 changes.
      for (int i = 13; i < NL; i++) begin
         row2Exp[i*EW +: EW] = 16'(16'hB000 + i - 13);
      end
      weBefore = weCount;
      applyStimulus(1'b1, 32'd45, rampRow(16'hB000), '0, -1, "abort45", 1'b0, acc);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkCount("abort_req_ready", req_ready, 1);
      repeat (8) @(negedge clk);
      checkCount("abort_write_pulses", weCount - weBefore, 1);
      checkOutput("abort_row32", memRows[2], row2Exp);
      checkOutput("abort_row48", memRows[3], row3Exp);

      // Top-of-memory wrap: k=9, second row is row 0.
      for (int i = 0; i < NL; i++) begin
         wrapExp[i*EW +: EW] = (i < 7) ? 16'(16'h0F09 + i) : 16'(16'h0A00 + i - 7);
      end
      applyStimulus(1'b0, 32'hFFFF_FFF9, '0, wrapExp, 3, "wrap", 1'b0, acc);
      checkCount("wrap_mem_a_row0", mem_a, 32'hFFFF_FFF0);
      @(negedge clk);
      checkCount("wrap_mem_a_row1", mem_a, 0);
      waitDrain("wrap");

      // req_valid held high: accepts spaced three edges apart.
      prevAcc = -1;
      for (int r = 0; r < 3; r++) begin
         applyStimulus(1'b0, 32'd32, '0, row2Exp, 2, "b2b", 1'b1, acc);
         if (r > 0) begin
            checkCount("b2b_accept_spacing", acc - prevAcc, 3);
         end
         prevAcc = acc;
      end
      req_valid = 1'b0;
      waitDrain("b2b");

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checksMade, checksFailed);
      $finish;
   end

endmodule
